// File: rtl/ex_muldiv_seq_if.sv
// ex_muldiv_seq_if
//   Bundles the EX-stage MUL/DIV/MOD sequencer signals.
//   slave  : the sequencer side (takes the request and control, drives the response).
//   master : the EX-stage side (drives the request and control, takes the response).
//   Signals:
//     Start       pipeline enable, 0 freezes the sequencer
//     Flush       synchronous abort
//     Req_Valid   request present
//     Req_Ready   sequencer can accept
//     Op          00 MUL, 01 DIV, 10 MOD, 11 reserved
//     A, B        signed operands
//     Busy        sequencer not idle
//     Stall       hold the upstream pipeline
//     Rsp_Valid   one-cycle result qualifier
//     Rsp_Result  product low half / quotient / remainder
//     Rsp_DivZero DIV/MOD had B == 0
interface ex_muldiv_seq_if #(parameter int XLEN = 32);
  logic            Start;
  logic            Flush;
  logic            Req_Valid;
  logic            Req_Ready;
  logic [1:0]      Op;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            Busy;
  logic            Stall;
  logic            Rsp_Valid;
  logic [XLEN-1:0] Rsp_Result;
  logic            Rsp_DivZero;

  modport slave (
    input  Start, Flush, Req_Valid, Op, A, B,
    output Req_Ready, Busy, Stall, Rsp_Valid, Rsp_Result, Rsp_DivZero
  );

  modport master (
    output Start, Flush, Req_Valid, Op, A, B,
    input  Req_Ready, Busy, Stall, Rsp_Valid, Rsp_Result, Rsp_DivZero
  );
endinterface

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq
//   Multi-cycle sequencer for the EX-stage MUL/DIV/MOD operations. Runs an
//   iterative shift-add multiply or a restoring divide on operand magnitudes,
//   holds the pipeline with Stall while working, applies the sign correction,
//   and presents the result for exactly one (Start-qualified) cycle.
//   Ports:
//     Clk  rising-edge clock
//     Rst  asynchronous active-low reset
//     bus  ex_muldiv_seq_if.slave (request, control and response signals)
module ex_muldiv_seq #(
  parameter int XLEN = 32
) (
  input logic             Clk,
  input logic             Rst,
  ex_muldiv_seq_if.slave  bus
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ITER  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] OP_MUL = 2'd0;
  localparam logic [1:0] OP_DIV = 2'd1;
  localparam logic [1:0] OP_MOD = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic [XLEN-1:0]   mag_b_q, mag_b_d;
  // MUL: {partial product high half, remaining multiplier bits}.
  // DIV/MOD: low half starts as |A| and fills with quotient bits from the right.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              divzero_q, divzero_d;

  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_trial;

  // |MIN| is 2^(XLEN-1), which still fits as an unsigned XLEN-bit magnitude.
  assign abs_a = bus.A[XLEN-1] ? -bus.A : bus.A;
  assign abs_b = bus.B[XLEN-1] ? -bus.B : bus.B;

  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
  assign div_shift = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
  // A borrow out of the trial subtraction means the divisor did not fit.
  assign div_trial = div_shift - {1'b0, mag_b_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    mag_b_d   = mag_b_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    result_d  = result_q;
    divzero_d = divzero_q;

    if (bus.Flush) begin
      state_d = S_IDLE;
    end else if (bus.Start) begin
      case (state_q)
        S_IDLE: begin
          if (bus.Req_Valid) begin
            op_d     = bus.Op;
            sign_a_d = bus.A[XLEN-1];
            sign_b_d = bus.B[XLEN-1];
            mag_b_d  = abs_b;
            acc_d    = {{XLEN{1'b0}}, abs_a};
            rem_d    = '0;
            cnt_d    = CW'(XLEN - 1);
            if (bus.Op == OP_RSV) begin
              result_d  = '0;
              divzero_d = 1'b0;
              state_d   = S_DONE;
            end else if (bus.Op != OP_MUL && bus.B == '0) begin
              result_d  = (bus.Op == OP_DIV) ? '1 : bus.A;
              divzero_d = 1'b1;
              state_d   = S_DONE;
            end else begin
              state_d = S_ITER;
            end
          end
        end
        S_ITER: begin
          if (op_q == OP_MUL) begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
          end else begin
            rem_d = div_trial[XLEN] ? div_shift : div_trial;
            acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~div_trial[XLEN]};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_d = S_FIXUP;
          end
        end
        S_FIXUP: begin
          case (op_q)
            OP_MUL, OP_DIV: result_d = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
            OP_MOD:         result_d = sign_a_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
            default:        result_d = '0;
          endcase
          divzero_d = 1'b0;
          state_d   = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      mag_b_q   <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      mag_b_q   <= mag_b_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
      divzero_q <= divzero_d;
    end
  end

  assign bus.Req_Ready   = (state_q == S_IDLE) & ~bus.Flush;
  assign bus.Busy        = (state_q != S_IDLE);
  // Stall drops in DONE so the pipeline captures the result that cycle.
  assign bus.Stall       = (state_q == S_ITER) | (state_q == S_FIXUP) |
                           ((state_q == S_IDLE) & bus.Req_Valid & ~bus.Flush);
  assign bus.Rsp_Valid   = (state_q == S_DONE);
  assign bus.Rsp_Result  = result_q;
  assign bus.Rsp_DivZero = divzero_q;

endmodule
